// File: rtl/pipe_pkg.sv
// Shared definitions for the PIPE receive framer: K-symbol codes, FSM states,
// output beat payload and default length limits.
package pipe_pkg;

   localparam logic [7:0] K_STP = 8'hFB;
   localparam logic [7:0] K_SDP = 8'h5C;
   localparam logic [7:0] K_END = 8'hFD;
   localparam logic [7:0] K_EDB = 8'hFE;
   localparam logic [7:0] K_COM = 8'hBC;
   localparam logic [7:0] K_SKP = 8'h1C;

   localparam int unsigned DEF_MAX_TLP_LEN = 4096;
   localparam int unsigned DEF_MIN_TLP_LEN = 18;
   localparam int unsigned DEF_DLLP_LEN    = 6;
   localparam int unsigned DEF_CNT_W       = 16;

   typedef enum logic [1:0] {IDLE, IN_TLP, IN_DLLP, DROP} rx_state_t;

   typedef enum logic [2:0] {
      KC_DATA, KC_STP, KC_SDP, KC_END, KC_EDB, KC_COM, KC_SKP, KC_BAD
   } sym_kind_t;

   typedef struct packed {
      logic [7:0] data;
      logic       valid;
      logic       sop;
      logic       eop;
      logic       err;
      logic       is_dllp;
   } rx_beat_t;

   // Classify one received symbol; unknown K codes map to KC_BAD.
   function automatic sym_kind_t sym_kind(input logic is_k, input logic [7:0] sym);
      sym_kind_t kind;
      kind = KC_BAD;
      if (!is_k) begin
         kind = KC_DATA;
      end else begin
         case (sym)
            K_STP:   kind = KC_STP;
            K_SDP:   kind = KC_SDP;
            K_END:   kind = KC_END;
            K_EDB:   kind = KC_EDB;
            K_COM:   kind = KC_COM;
            K_SKP:   kind = KC_SKP;
            default: kind = KC_BAD;
         endcase
      end
      return kind;
   endfunction

endpackage

// File: rtl/sat_cnt.sv
// Increment-enable counter that sticks at all-ones.
module sat_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: step unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_rx_framer.sv
// PCIe Gen1 x1 PIPE receive framer: strips STP/SDP/END/EDB framing and emits
// sop/eop-marked packet bytes with error flag and statistics counters.
// Optional SKP ordered-set statistics: define PIPE_RX_SKP_STATS_EN.
module pipe_rx_framer
   import pipe_pkg::*;
#(
   parameter int unsigned MAX_TLP_LEN = DEF_MAX_TLP_LEN,
   parameter int unsigned MIN_TLP_LEN = DEF_MIN_TLP_LEN,
   parameter int unsigned DLLP_LEN    = DEF_DLLP_LEN,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic             pcieclk,
   input  logic             rst,
   input  logic [7:0]       rxdata,
   input  logic             rxdatak,
   output logic [7:0]       out_data,
   output logic             out_valid,
   output logic             out_sop,
   output logic             out_eop,
   output logic             out_err,
   output logic             out_is_dllp,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] skp_cnt
);

   localparam int unsigned BC_W = $clog2(MAX_TLP_LEN + 2);

   rx_state_t       state_q, state_d;
   logic [BC_W-1:0] cnt_q, cnt_d;
   logic            hold_vld_q, hold_vld_d;
   logic            hold_sop_q, hold_sop_d;
   logic [7:0]      hold_data_q, hold_data_d;
   rx_beat_t        out_q, out_d;
   sym_kind_t       kind_c;
   logic            bad_len_c;
   logic            bad_c;
   logic            pkt_inc_c;
   logic            err_inc_c;

   assign kind_c = sym_kind(rxdatak, rxdata);

   // Framing FSM: hold one byte so eop/err can be attached once the next symbol arrives.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      hold_vld_d    = hold_vld_q;
      hold_sop_d    = hold_sop_q;
      hold_data_d   = hold_data_q;
      out_d         = out_q;
      out_d.valid   = 1'b0;
      out_d.sop     = 1'b0;
      out_d.eop     = 1'b0;
      out_d.err     = 1'b0;
      pkt_inc_c     = 1'b0;
      err_inc_c     = 1'b0;
      bad_c         = 1'b0;
      bad_len_c     = (state_q == IN_DLLP) ? (cnt_q != BC_W'(DLLP_LEN))
                                           : (cnt_q < BC_W'(MIN_TLP_LEN));

      unique case (state_q)
         IDLE, DROP: begin
            if (kind_c == KC_STP) begin
               state_d = IN_TLP;
               cnt_d   = '0;
            end else if (kind_c == KC_SDP) begin
               state_d = IN_DLLP;
               cnt_d   = '0;
            end else if ((kind_c == KC_END) || (kind_c == KC_EDB)) begin
               state_d = IDLE;
            end
         end

         IN_TLP, IN_DLLP: begin
            if (hold_vld_q) begin
               out_d.valid   = 1'b1;
               out_d.data    = hold_data_q;
               out_d.sop     = hold_sop_q;
               out_d.is_dllp = (state_q == IN_DLLP);
            end
            if (kind_c == KC_DATA) begin
               if (cnt_q == BC_W'(MAX_TLP_LEN)) begin
                  // Length overflow: close with error and discard the rest.
                  out_d.eop  = 1'b1;
                  out_d.err  = 1'b1;
                  err_inc_c  = 1'b1;
                  hold_vld_d = 1'b0;
                  state_d    = DROP;
               end else begin
                  hold_vld_d  = 1'b1;
                  hold_data_d = rxdata;
                  hold_sop_d  = (cnt_q == '0);
                  cnt_d       = cnt_q + 1'b1;
               end
            end else begin
               // Any K symbol terminates the current packet.
               bad_c = (kind_c != KC_END) || bad_len_c;
               if (hold_vld_q) begin
                  out_d.eop = 1'b1;
                  out_d.err = bad_c;
                  pkt_inc_c = !bad_c;
                  err_inc_c = bad_c;
               end else begin
                  err_inc_c = 1'b1;
               end
               hold_vld_d = 1'b0;
               cnt_d      = '0;
               if (kind_c == KC_STP)      state_d = IN_TLP;
               else if (kind_c == KC_SDP) state_d = IN_DLLP;
               else                       state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State, hold and output registers.
   always_ff @(posedge pcieclk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hold_vld_q  <= 1'b0;
         hold_sop_q  <= 1'b0;
         hold_data_q <= '0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_vld_q  <= hold_vld_d;
         hold_sop_q  <= hold_sop_d;
         hold_data_q <= hold_data_d;
         out_q       <= out_d;
      end
   end

   assign out_data    = out_q.data;
   assign out_valid   = out_q.valid;
   assign out_sop     = out_q.sop;
   assign out_eop     = out_q.eop;
   assign out_err     = out_q.err;
   assign out_is_dllp = out_q.is_dllp;

   sat_cnt #(.W(CNT_W)) u_pkt_cnt (.clk(pcieclk), .rst(rst), .inc_i(pkt_inc_c), .cnt_o(pkt_cnt));
   sat_cnt #(.W(CNT_W)) u_err_cnt (.clk(pcieclk), .rst(rst), .inc_i(err_inc_c), .cnt_o(err_cnt));

`ifdef PIPE_RX_SKP_STATS_EN
   logic [1:0] skp_seq_q, skp_seq_d;
   logic       skp_inc_c;

   // Track COM followed by three SKP while idle between packets.
   always_comb begin
      skp_seq_d = '0;
      skp_inc_c = 1'b0;
      if (state_q == IDLE) begin
         if (kind_c == KC_COM) begin
            skp_seq_d = 2'd1;
         end else if ((kind_c == KC_SKP) && (skp_seq_q != 2'd0)) begin
            if (skp_seq_q == 2'd3) skp_inc_c = 1'b1;
            else                   skp_seq_d = skp_seq_q + 2'd1;
         end
      end
   end

   // SKP sequence position register.
   always_ff @(posedge pcieclk) begin
      if (rst) skp_seq_q <= '0;
      else     skp_seq_q <= skp_seq_d;
   end

   sat_cnt #(.W(CNT_W)) u_skp_cnt (.clk(pcieclk), .rst(rst), .inc_i(skp_inc_c), .cnt_o(skp_cnt));
`else
   assign skp_cnt = '0;
`endif

endmodule
